// File: rtl/keypad_bcd_calc_if.sv
// Keypad-to-display bundle for keypad_bcd_calc: one-pulse key input on one side,
// packed BCD display plus status on the other.
interface keypad_bcd_calc_if #(
  parameter int DIGITS = 2
);
  logic                        key_valid;
  logic [3:0]                  key_code;
  logic [4*(DIGITS+1)-1:0]     disp_bcd;
  logic                        disp_neg;
  logic [1:0]                  disp_sel;
  logic                        busy;
  logic                        done;

  modport master (
    output key_valid, key_code,
    input  disp_bcd, disp_neg, disp_sel, busy, done
  );

  modport slave (
    input  key_valid, key_code,
    output disp_bcd, disp_neg, disp_sel, busy, done
  );
endinterface

// File: rtl/keypad_bcd_calc.sv
// Key-driven N-digit BCD add/sub calculator with digit-serial datapath.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero display nibbles to 4'hF.
module keypad_bcd_calc #(
  parameter int DIGITS = 2
) (
  input logic              clk_150,
  input logic              rst_n,
  keypad_bcd_calc_if.slave bus
);
  localparam int AW = 4 * DIGITS;
  localparam int RW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, RESULT} state_t;

  state_t        state, next_state;
  logic [AW-1:0] a, b, x, y, acc, acc_next;
  logic [RW-1:0] r;
  logic [CW-1:0] cnt_a, cnt_b, idx;
  logic          op_sub, neg, cy, cy_next, done_q;
  logic [4:0]    sum, diff;
  logic [3:0]    dig;

  logic key_dig, key_op, key_eq, key_clr, key_bs, chain_ok, last_digit;

  assign key_dig    = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_op     = bus.key_valid && (bus.key_code == 4'd10 || bus.key_code == 4'd11);
  assign key_eq     = bus.key_valid && (bus.key_code == 4'd12);
  assign key_clr    = bus.key_valid && (bus.key_code == 4'd13);
  assign key_bs     = bus.key_valid && (bus.key_code == 4'd14);
  // A result can only be reused as operand A if it is non-negative and fits in DIGITS.
  assign chain_ok   = !neg && (r[RW-1 -: 4] == 4'd0);
  assign last_digit = (idx == LAST);

  // x/y shift right one nibble per CALC cycle, so the current digit is always the LSD.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dig     = 4'd0;
    cy_next = 1'b0;
    sum     = 5'(x[3:0]) + 5'(y[3:0]) + 5'(cy);
    diff    = 5'(x[3:0]) - 5'(y[3:0]) - 5'(cy);
    if (!op_sub) begin
      if (sum > 5'd9) begin
        dig     = 4'(sum - 5'd10);
        cy_next = 1'b1;
      end else begin
        dig = sum[3:0];
      end
    end else begin
      if (diff[4]) begin
        dig     = 4'(diff + 5'd10);
        cy_next = 1'b1;
      end else begin
        dig = diff[3:0];
      end
    end
    acc_next = (acc >> 4) | (AW'(dig) << (4 * (DIGITS - 1)));
  end

  always_ff @(posedge clk_150 or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!rst_n) state <= ENTER_A;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (key_clr) begin
      next_state = ENTER_A;
    end else begin
      case (state)
        ENTER_A: if (key_op) next_state = ENTER_B;
        ENTER_B: if (key_eq) next_state = CALC;
        CALC:    if (last_digit) next_state = RESULT;
        RESULT: begin
          if (key_dig)                  next_state = ENTER_A;
          else if (key_op && chain_ok)  next_state = ENTER_B;
        end
        default: next_state = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk_150 or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0; b <= '0; r <= '0; x <= '0; y <= '0; acc <= '0;
      cnt_a <= '0; cnt_b <= '0; idx <= '0;
      op_sub <= 1'b0; neg <= 1'b0; cy <= 1'b0; done_q <= 1'b0;
    end else if (key_clr) begin
      a <= '0; b <= '0; r <= '0; x <= '0; y <= '0; acc <= '0;
      cnt_a <= '0; cnt_b <= '0; idx <= '0;
      op_sub <= 1'b0; neg <= 1'b0; cy <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ENTER_A: begin
          if (key_dig && cnt_a != FULL) begin
            a     <= (a << 4) | AW'(bus.key_code);
            cnt_a <= cnt_a + 1'b1;
          end else if (key_bs && cnt_a != '0) begin
            a     <= a >> 4;
            cnt_a <= cnt_a - 1'b1;
          end else if (key_op) begin
            op_sub <= bus.key_code[0];
            b      <= '0;
            cnt_b  <= '0;
          end
        end
        ENTER_B: begin
          if (key_dig && cnt_b != FULL) begin
            b     <= (b << 4) | AW'(bus.key_code);
            cnt_b <= cnt_b + 1'b1;
          end else if (key_bs && cnt_b != '0) begin
            b     <= b >> 4;
            cnt_b <= cnt_b - 1'b1;
          end else if (key_op) begin
            op_sub <= bus.key_code[0];
          end else if (key_eq) begin
            // Packed BCD compares like binary, so a swap keeps subtraction non-negative.
            if (op_sub && a < b) begin
              x <= b; y <= a; neg <= 1'b1;
            end else begin
              x <= a; y <= b; neg <= 1'b0;
            end
            cy  <= 1'b0;
            idx <= '0;
            acc <= '0;
          end
        end
        CALC: begin
          x   <= x >> 4;
          y   <= y >> 4;
          acc <= acc_next;
          cy  <= cy_next;
          idx <= idx + 1'b1;
          if (last_digit) begin
            r      <= {3'b000, cy_next & ~op_sub, acc_next};
            done_q <= 1'b1;
          end
        end
        RESULT: begin
          if (key_dig) begin
            a     <= AW'(bus.key_code);
            cnt_a <= CW'(1);
          end else if (key_op && chain_ok) begin
            a      <= r[AW-1:0];
            cnt_a  <= FULL;
            op_sub <= bus.key_code[0];
            b      <= '0;
            cnt_b  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  logic [RW-1:0] raw;
  logic [1:0]    sel;
`ifdef LEADING_ZERO_BLANK_EN
  logic [RW-1:0] disp;
  logic          lead;
`endif

  always_comb begin
    raw = '0;
    sel = 2'd0;
    case (state)
      ENTER_A:       begin raw = RW'(a); sel = 2'd0; end
      ENTER_B, CALC: begin raw = RW'(b); sel = 2'd1; end
      RESULT:        begin raw = r;      sel = 2'd2; end
      default:       ;
    endcase
    bus.disp_sel = sel;
    bus.disp_neg = (state == RESULT) && neg;
    bus.busy     = (state == CALC);
    bus.done     = done_q;
`ifdef LEADING_ZERO_BLANK_EN
    disp = raw;
    lead = 1'b1;
    for (int i = DIGITS; i > 0; i--) begin
      if (lead && raw[4*i +: 4] == 4'd0) disp[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    bus.disp_bcd = disp;
`else
    bus.disp_bcd = raw;
`endif
  end
endmodule

// File: tb/tb_keypad_bcd_calc.sv
// Self-checking bench for keypad_bcd_calc (DIGITS=2): directed plan steps, then random
// keys against an integer-arithmetic reference model.
module tb_keypad_bcd_calc;
  localparam int D  = 2;
  localparam int RW = 4 * (D + 1);
  localparam int M_A = 0, M_B = 1, M_R = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [11:0] E035 = 12'hF35, E012 = 12'hF12, E019 = 12'hF19;
  localparam logic [11:0] E030 = 12'hF30, E009 = 12'hFF9, E000 = 12'hFF0;
`else
  localparam logic [11:0] E035 = 12'h035, E012 = 12'h012, E019 = 12'h019;
  localparam logic [11:0] E030 = 12'h030, E009 = 12'h009, E000 = 12'h000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #3 clk = ~clk;

  keypad_bcd_calc_if #(.DIGITS(D)) bus ();
  keypad_bcd_calc #(.DIGITS(D)) dut (.clk_150(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: operands as plain integers with digit counts.
  int ma, mb, mr, ca, cb, mmode;
  bit msub, mneg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] to_bcd(input int v);
    logic [RW-1:0] res;
    int t;
    res = '0;
    t = v;
    for (int i = 0; i <= D; i++) begin
      res[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = D; i > 0; i--) begin
      if (res[4*i +: 4] != 4'd0) break;
      res[4*i +: 4] = 4'hF;
    end
`endif
    return res;
  endfunction

  function automatic void model_reset();
    ma = 0; mb = 0; mr = 0; ca = 0; cb = 0; mmode = M_A; msub = 0; mneg = 0;
  endfunction

  function automatic void model_key(input logic [3:0] k);
    int kv;
    kv = int'(k);
    if (kv == 13) begin
      model_reset();
    end else if (mmode == M_A || mmode == M_B) begin
      if (kv <= 9) begin
        if (mmode == M_A && ca < D) begin ma = ma * 10 + kv; ca++; end
        if (mmode == M_B && cb < D) begin mb = mb * 10 + kv; cb++; end
      end else if (kv == 14) begin
        if (mmode == M_A && ca > 0) begin ma = ma / 10; ca--; end
        if (mmode == M_B && cb > 0) begin mb = mb / 10; cb--; end
      end else if (kv == 10 || kv == 11) begin
        msub = (kv == 11);
        if (mmode == M_A) begin mb = 0; cb = 0; mmode = M_B; end
      end else if (kv == 12 && mmode == M_B) begin
        if (!msub)        begin mr = ma + mb; mneg = 0; end
        else if (ma < mb) begin mr = mb - ma; mneg = 1; end
        else              begin mr = ma - mb; mneg = 0; end
        mmode = M_R;
      end
    end else begin
      if (kv <= 9) begin
        ma = kv; ca = 1; mmode = M_A;
      end else if ((kv == 10 || kv == 11) && !mneg && mr < 10 ** D) begin
        ma = mr; ca = D; msub = (kv == 11); mb = 0; cb = 0; mmode = M_B;
      end
    end
  endfunction

  task automatic check_display(input string tag);
    int v;
    v = (mmode == M_A) ? ma : (mmode == M_B) ? mb : mr;
    check({tag, "_bcd"}, 32'(bus.disp_bcd), 32'(to_bcd(v)));
    check({tag, "_sel"}, 32'(bus.disp_sel), 32'(mmode));
    check({tag, "_neg"}, 32'(bus.disp_neg), 32'(mmode == M_R && mneg));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Presses one key, follows any calculation to completion, then compares against the model.
  task automatic key(input logic [3:0] k, input string tag);
    bit calc;
    int n;
    calc = (mmode == M_B && k == 4'd12);
    press(k);
    if (calc) begin
      n = 1;
      check({tag, "_calc_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_calc_bcd"}, 32'(bus.disp_bcd), 32'(to_bcd(mb)));
      while (!bus.done && n < 20) begin
        @(negedge clk);
        n++;
        if (!bus.done) check({tag, "_busy_hold"}, 32'(bus.busy), 32'd1);
      end
      check({tag, "_done_latency"}, 32'(n), 32'(D + 1));
      check({tag, "_done"}, 32'(bus.done), 32'd1);
    end
    model_key(k);
    check_display(tag);
    if (calc) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv;
    logic [3:0] k;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_bcd", 32'(bus.disp_bcd), 32'(E000));
    check("rst_sel", 32'(bus.disp_sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_display("post_rst");

    // 47 + 85
    key(4'd4, "a4"); key(4'd7, "a7"); key(4'd10, "add"); key(4'd8, "b8"); key(4'd5, "b5");
    key(4'd12, "eq_add");
    check("add_132", 32'(bus.disp_bcd), 32'h132);
    check("add_132_sel", 32'(bus.disp_sel), 32'd2);

    // 23 - 58 and 58 - 23
    key(4'd13, "clr");
    key(4'd2, "s2"); key(4'd3, "s3"); key(4'd11, "sub"); key(4'd5, "s5"); key(4'd8, "s8");
    key(4'd12, "eq_subneg");
    check("sub_neg_bcd", 32'(bus.disp_bcd), 32'(E035));
    check("sub_neg_flag", 32'(bus.disp_neg), 32'd1);
    key(4'd5, "t5"); key(4'd8, "t8"); key(4'd11, "sub2"); key(4'd2, "t2"); key(4'd3, "t3");
    key(4'd12, "eq_subpos");
    check("sub_pos_bcd", 32'(bus.disp_bcd), 32'(E035));
    check("sub_pos_flag", 32'(bus.disp_neg), 32'd0);

    // Entry limits and backspace
    key(4'd13, "clr2");
    key(4'd1, "e1"); key(4'd2, "e2"); key(4'd3, "e3_full");
    check("full_a", 32'(bus.disp_bcd), 32'(E012));
    key(4'd14, "bs"); key(4'd9, "e9");
    check("bs_a", 32'(bus.disp_bcd), 32'(E019));
    key(4'd10, "op_to_b"); key(4'd14, "bs_empty");
    check("bs_empty_b", 32'(bus.disp_bcd), 32'(E000));

    // Clear in the first CALC cycle
    key(4'd3, "c3"); key(4'd12, "pre");  // B=3 then equals via raw sequence below is not used
    key(4'd13, "clr3");
    key(4'd1, "c1"); key(4'd2, "c2"); key(4'd10, "cadd"); key(4'd3, "cb3");
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd12;
    @(negedge clk);
    bus.key_code  = 4'd13;
    @(negedge clk);
    bus.key_valid = 1'b0;
    model_key(4'd12);
    model_key(4'd13);
    check_display("clr_calc");
    check("clr_calc_bcd", 32'(bus.disp_bcd), 32'(E000));
    repeat (4) begin
      @(negedge clk);
      check("clr_calc_nodone", 32'(bus.done), 32'd0);
    end

    // Asynchronous reset in the middle of CALC
    key(4'd4, "r4"); key(4'd10, "radd"); key(4'd6, "r6");
    press(4'd12);
    check("rst_calc_busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_sel", 32'(bus.disp_sel), 32'd0);
    check("arst_bcd", 32'(bus.disp_bcd), 32'(E000));
    check("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("arst_nodone", 32'(bus.done), 32'd0);
    end
    check_display("arst_after");

    // Chaining
    key(4'd1, "h1"); key(4'd0, "h0"); key(4'd10, "hadd"); key(4'd2, "h2"); key(4'd0, "h0b");
    key(4'd12, "heq");
    check("chain_r30", 32'(bus.disp_bcd), 32'(E030));
    key(4'd10, "chain_op"); key(4'd5, "h5"); key(4'd12, "heq2");
    check("chain_r35", 32'(bus.disp_bcd), 32'(E035));
    key(4'd9, "n9"); key(4'd9, "n9b"); key(4'd10, "nadd"); key(4'd9, "n9c"); key(4'd9, "n9d");
    key(4'd12, "neq");
    check("ovf_198", 32'(bus.disp_bcd), 32'h198);
    key(4'd10, "ovf_op");
    check("ovf_op_ignored_bcd", 32'(bus.disp_bcd), 32'h198);
    check("ovf_op_ignored_sel", 32'(bus.disp_sel), 32'd2);

    // Single-digit result display
    key(4'd13, "clr4");
    key(4'd7, "z7"); key(4'd10, "zadd"); key(4'd2, "z2"); key(4'd12, "zeq");
    check("blank_009", 32'(bus.disp_bcd), 32'(E009));

    // Random key stream against the model
    key(4'd13, "clr_rnd");
    for (int i = 0; i < 400; i++) begin
      rv = int'($urandom_range(0, 99));
      if (rv < 55)      k = 4'($urandom_range(0, 9));
      else if (rv < 67) k = 4'($urandom_range(10, 11));
      else if (rv < 79) k = 4'd12;
      else if (rv < 88) k = 4'd14;
      else if (rv < 91) k = 4'd13;
      else              k = 4'd15;
      key(k, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_bcd_calc.md
Name: keypad_bcd_calc

Overview:
- Parametrised N-digit BCD calculator core.
- Consumes one-pulse keypad codes and keeps operands A and B as packed BCD with digit-count tracking.
- Performs digit-serial BCD add or subtract with a sign flag, then presents A, B or the result to the 4-digit scan/14-segment display chain.
- Replaces the fixed 2-digit add/sub datapath and toggle-button operand/tens selection with key-driven entry.

Parameters:
- DIGITS, 2, operand width in BCD digits (1..7); result is DIGITS+1 digits.

Ports:
- clk_150  input  1  keypad scan clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle pulse; key_code is valid this cycle.
- key_code  input  4  0-9 digit, 10 add, 11 sub, 12 equals, 13 clear, 14 backspace, 15 ignored.
- disp_bcd  output  4*(DIGITS+1)  packed BCD for display, MSD in top nibble.
- disp_neg  output  1  result is negative; drives minus digit upstream.
- disp_sel  output  2  0 showing A, 1 showing B, 2 showing result.
- busy  output  1  high during CALC.
- done  output  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset is asynchronous and active low, on rst_n; the clock is clk_150.
- Reset values: A=B=R=0, counts=0, op=add, state ENTER_A, disp_bcd=0, disp_neg=0, disp_sel=0, busy=0, done=0.
- States: ENTER_A, ENTER_B, CALC, RESULT.
- Digit key in ENTER_A or ENTER_B:
  - If count<DIGITS, the operand shifts left one nibble, key enters the LSD, count++.
  - If count==DIGITS, the key is ignored (full).
- Backspace in ENTER_A or ENTER_B: if count>0, shift right one nibble, MSD=0, count--. At count==0 it is ignored.
- Op key (10/11):
  - ENTER_A: latch op, clear B and count_b, go to ENTER_B.
  - ENTER_B: overwrite op only.
  - RESULT: chain (A<=R low DIGITS digits, count_a=DIGITS, op latched, B cleared, go to ENTER_B) only when disp_neg=0 and R MSD==0. Otherwise ignored.
- Equals: accepted only in ENTER_B, then go to CALC. Ignored in every other state.
- Clear (13): accepted in any state including CALC. Synchronously restores all reset values; same cycle priority over everything else.
- Entry into CALC, cycle t (equals accepted):
  - For sub, compare A and B as unsigned vectors; BCD order equals magnitude order.
  - If A<B, operands are swapped and neg=1. Otherwise neg=0.
  - Add always has neg=0.
- CALC, cycles t+1..t+DIGITS, busy=1, one digit per cycle, LSD first:
  - add: s=a+b+c; if s>9 then digit=s-10 and c=1, else c=0.
  - sub: d=a-b-borrow; if d<0 then digit=d+10 and borrow=1.
  - After the last digit, R MSD = final carry for add, and 0 for sub.
  - All keys except clear are ignored during CALC.
- RESULT is entered at t+DIGITS+1: done=1 for that cycle only, busy=0, disp_neg=neg.
- Display:
  - ENTER_A shows A, zero-extended.
  - ENTER_B and CALC show B.
  - RESULT shows R.
  - disp_neg is 0 outside RESULT.
- Digit keys in RESULT start a fresh calculation: A cleared, the key is loaded as the first digit of A, state ENTER_A.
- key_valid held high for several cycles is treated as repeated keys; the upstream one-pulse stage is responsible for single pulses.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: disp_bcd leading zero nibbles, above the LSD, are replaced by 4'hF (blank code for bcd_d). The LSD is always shown.
- Undefined: all nibbles are shown as numeric, including leading zeros.

Test Plan:
- DIGITS=2; keys 4,7,add,8,5,equals:
  - busy high for 2 cycles, done 3 cycles after equals.
  - disp_bcd=0x132, disp_neg=0, disp_sel=2.
- Keys 2,3,sub,5,8,equals -> disp_bcd=0x035, disp_neg=1. Keys 5,8,sub,2,3,equals -> disp_bcd=0x035, disp_neg=0.
- Keys 1,2,3 in ENTER_A -> A=0x12 (third digit ignored). Then backspace,9 -> A=0x19. Backspace on empty B -> no change.
- Clear pulse in the first CALC cycle:
  - next cycle state ENTER_A, all zero, busy=0, no done pulse.
  - Async rst_n low mid-CALC gives the same result immediately.
- Chaining:
  - 1,0,add,2,0,equals (R=0x030) then add,5,equals -> 0x035.
  - After 9,9,add,9,9,equals (R=0x198), an op key is ignored.
- With LEADING_ZERO_BLANK_EN: 7,add,2,equals -> disp_bcd=0xFF9. Without the macro -> 0x009.
